// File: rtl/dmem_pkg.sv
// Shared memop encodings and access-decode helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  // Unsigned encodings only make sense for loads; stores must use the size-only codes.
  function automatic logic mop_legal(input logic [2:0] memop, input logic [1:0] lane,
                                     input logic we);
    logic ok;
    ok = 1'b0;
    case (memop)
      MOP_B:   ok = 1'b1;
      MOP_H:   ok = ~lane[0];
      MOP_W:   ok = (lane == 2'b00);
      MOP_BU:  ok = ~we;
      MOP_HU:  ok = ~we & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] mop_byte_en(input logic [2:0] memop, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (memop[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-to-data-memory bus: address/data/memop/we from the core, load data and status back.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [2:0]  memop;
  logic        we;
  logic [31:0] dataout;
  logic        err;
  logic [15:0] wr_cnt;

  modport master (output addr, datain, memop, we, input dataout, err, wr_cnt);
  modport slave  (input addr, datain, memop, we, output dataout, err, wr_cnt);
endinterface

// File: rtl/dmem_byte_bank.sv
// One byte lane of data memory: DEPTH x 8 synchronous RAM, read-first, one-cycle read latency.
module dmem_byte_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  always_comb begin
    rdata_d = mem[addr];
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32I core: byte-banked storage, sized/signed loads, sticky error.
// Optional macro DMEM_BYPASS_EN: same-cycle load of a word being stored returns the merged new word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic   clock,
  input  logic   reset,
  dmem_if.slave  bus
);

  logic [1:0]    lane_s;
  logic [AW-1:0] widx_s;
  logic          legal_s;
  logic [3:0]    be_s;
  logic [3:0]    bank_we_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   dataout_s;
  logic          unused_addr_s;

  logic [1:0]  lane_d,   lane_q;
  logic [2:0]  memop_d,  memop_q;
  logic        legal_d,  legal_q;
  logic        err_d,    err_q;
  logic [15:0] wr_cnt_d, wr_cnt_q;

  assign lane_s        = bus.addr[1:0];
  assign widx_s        = bus.addr[AW+1:2];
  assign unused_addr_s = ^bus.addr[31:AW+2];
  assign legal_s       = mop_legal(bus.memop, lane_s, bus.we);
  assign be_s          = mop_byte_en(bus.memop, lane_s);
  assign bank_we_s     = (!reset && bus.we && legal_s) ? be_s : 4'b0000;

  // Replicate narrow store data onto every lane so the byte enables pick the right copy.
  always_comb begin
    wdata_s = bus.datain;
    case (bus.memop[1:0])
      2'b00:   wdata_s = {4{bus.datain[7:0]}};
      2'b01:   wdata_s = {2{bus.datain[15:0]}};
      default: wdata_s = bus.datain;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_bank
    dmem_byte_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clock (clock),
      .we    (bank_we_s[i]),
      .addr  (widx_s),
      .wdata (wdata_s[8*i +: 8]),
      .rdata (rd_word_s[8*i +: 8])
    );
  end

`ifdef DMEM_BYPASS_EN
  logic [3:0]  be_d,    be_q;
  logic [31:0] wdata_d, wdata_q;

  always_comb begin
    if (reset) begin
      be_d    = 4'b0000;
      wdata_d = 32'h0000_0000;
    end else begin
      be_d    = bank_we_s;
      wdata_d = wdata_s;
    end
  end

  always_ff @(posedge clock) begin
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  // Lanes written in the sampled cycle come from the store data, the rest from the bank.
  always_comb begin
    word_s = rd_word_s;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) begin
        word_s[8*i +: 8] = wdata_q[8*i +: 8];
      end else begin
        word_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end
`else
  assign word_s = rd_word_s;
`endif

  always_comb begin
    if (reset) begin
      lane_d   = 2'b00;
      memop_d  = 3'b000;
      legal_d  = 1'b0;
      err_d    = 1'b0;
      wr_cnt_d = 16'h0000;
    end else begin
      lane_d   = lane_s;
      memop_d  = bus.memop;
      legal_d  = legal_s;
      err_d    = err_q | ~legal_s;
      wr_cnt_d = (bus.we && legal_s) ? wr_cnt_q + 16'h0001 : wr_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    lane_q   <= lane_d;
    memop_q  <= memop_d;
    legal_q  <= legal_d;
    err_q    <= err_d;
    wr_cnt_q <= wr_cnt_d;
  end

  assign byte_s = word_s[{lane_q, 3'b000} +: 8];
  assign half_s = lane_q[1] ? word_s[31:16] : word_s[15:0];

  // An illegal sampled access forces zero so stale or undefined bank data never leaks out.
  always_comb begin
    dataout_s = 32'h0000_0000;
    if (!legal_q) begin
      dataout_s = 32'h0000_0000;
    end else begin
      case (memop_q)
        MOP_B:   dataout_s = {{24{byte_s[7]}}, byte_s};
        MOP_BU:  dataout_s = {24'h00_0000, byte_s};
        MOP_H:   dataout_s = {{16{half_s[15]}}, half_s};
        MOP_HU:  dataout_s = {16'h0000, half_s};
        MOP_W:   dataout_s = word_s;
        default: dataout_s = 32'h0000_0000;
      endcase
    end
  end

  assign bus.dataout = dataout_s;
  assign bus.err     = err_q;
  assign bus.wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table plus randomized traffic against a byte-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef DMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    logic        we;
    logic        chk;
    logic [31:0] exp_do;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [$];

  logic [7:0]  mem_m [4096];
  logic        err_m;
  logic [15:0] cnt_m;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic w);
    reset      = rst;
    bus.addr   = a;
    bus.datain = d;
    bus.memop  = op;
    bus.we     = w;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t v(input logic rst, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] op, input logic w, input logic chk,
                             input logic [31:0] edo, input logic eerr, input logic [15:0] ecnt);
    vec_t r;
    r.rst = rst; r.addr = a; r.data = d; r.op = op; r.we = w; r.chk = chk;
    r.exp_do = edo; r.exp_err = eerr; r.exp_cnt = ecnt;
    return r;
  endfunction

  // Reference rules straight from the access definition: size from memop, alignment by modulo.
  function automatic bit m_legal(input logic [2:0] op, input int a, input logic w);
    case (op)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !w;
      3'd5:    return !w && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] op);
    if (op[1:0] == 2'd0) return 1;
    else if (op[1:0] == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input int a);
    logic [31:0] val;
    int n;
    n = m_size(op);
    val = 32'h0;
    for (int k = 0; k < n; k++) val = val | (32'(mem_m[(a + k) % 4096]) << (8 * k));
    if (!op[2] && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
    return val;
  endfunction

  task automatic m_step(input logic rst, input logic [31:0] addr, input logic [31:0] d,
                        input logic [2:0] op, input logic w);
    int a;
    bit lg;
    logic [31:0] edo;
    a  = int'(addr[11:0]);
    lg = m_legal(op, a, w);
    edo = 32'h0;
    if (rst) begin
      err_m = 1'b0;
      cnt_m = 16'h0;
    end else begin
      if (lg && !BYP) edo = m_load(op, a);
      if (w && lg) begin
        for (int k = 0; k < m_size(op); k++) mem_m[(a + k) % 4096] = 8'(d >> (8 * k));
        cnt_m = cnt_m + 16'h1;
      end
      if (lg && BYP) edo = m_load(op, a);
      if (!lg) err_m = 1'b1;
    end
    step(rst, addr, d, op, w);
    check32("rand_dataout", bus.dataout, edo);
    check32("rand_err", {31'b0, bus.err}, {31'b0, err_m});
    check32("rand_wr_cnt", {16'b0, bus.wr_cnt}, {16'b0, cnt_m});
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rop;

    reset = 1'b1; bus.addr = 32'h0; bus.datain = 32'h0; bus.memop = 3'b000; bus.we = 1'b0;

    tbl.push_back(v(1'b1, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h0,        1'b0, 16'd0));
    tbl.push_back(v(1'b0, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h13, 32'h0,        3'b000, 1'b0, 1'b1, 32'hFFFFFFDE, 1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h13, 32'h0,        3'b100, 1'b0, 1'b1, 32'h000000DE, 1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b001, 1'b0, 1'b1, 32'hFFFFBEEF, 1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h12, 32'h0,        3'b101, 1'b0, 1'b1, 32'h0000DEAD, 1'b0, 16'd1));
    tbl.push_back(v(1'b0, 32'h11, 32'h000000AA, 3'b000, 1'b1, 1'b1,
                    BYP ? 32'hFFFFFFAA : 32'hFFFFFFBE, 1'b0, 16'd2));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'hDEADAAEF, 1'b0, 16'd2));
    tbl.push_back(v(1'b0, 32'h12, 32'h00001234, 3'b001, 1'b1, 1'b1,
                    BYP ? 32'h00001234 : 32'hFFFFDEAD, 1'b0, 16'd3));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h1234AAEF, 1'b0, 16'd3));
    tbl.push_back(v(1'b0, 32'h10 + DEPTH*4, 32'h0, 3'b010, 1'b0, 1'b1, 32'h1234AAEF, 1'b0, 16'd3));
    tbl.push_back(v(1'b0, 32'h10 + DEPTH*4, 32'h00000077, 3'b000, 1'b1, 1'b1,
                    BYP ? 32'h00000077 : 32'hFFFFFFEF, 1'b0, 16'd4));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h1234AA77, 1'b0, 16'd4));
    tbl.push_back(v(1'b0, 32'h20, 32'h22222222, 3'b010, 1'b1, 1'b0, 32'h0,        1'b0, 16'd5));
    tbl.push_back(v(1'b0, 32'h20, 32'h11111111, 3'b010, 1'b1, 1'b1,
                    BYP ? 32'h11111111 : 32'h22222222, 1'b0, 16'd6));
    tbl.push_back(v(1'b0, 32'h20, 32'h0,        3'b010, 1'b0, 1'b1, 32'h11111111, 1'b0, 16'd6));
    tbl.push_back(v(1'b0, 32'h12, 32'hFFFFFFFF, 3'b010, 1'b1, 1'b1, 32'h0,        1'b1, 16'd6));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h1234AA77, 1'b1, 16'd6));
    tbl.push_back(v(1'b0, 32'h11, 32'h0,        3'b001, 1'b0, 1'b1, 32'h0,        1'b1, 16'd6));
    tbl.push_back(v(1'b0, 32'h13, 32'h0,        3'b100, 1'b0, 1'b1, 32'h00000012, 1'b1, 16'd6));
    tbl.push_back(v(1'b1, 32'h10, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0,        1'b0, 16'd0));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h1234AA77, 1'b0, 16'd0));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b011, 1'b0, 1'b1, 32'h0,        1'b1, 16'd0));
    tbl.push_back(v(1'b1, 32'h0,  32'h0,        3'b000, 1'b0, 1'b1, 32'h0,        1'b0, 16'd0));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b100, 1'b1, 1'b1, 32'h0,        1'b1, 16'd0));
    tbl.push_back(v(1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 1'b1, 32'h1234AA77, 1'b1, 16'd0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].addr, tbl[i].data, tbl[i].op, tbl[i].we);
      if (tbl[i].chk) check32($sformatf("vec%0d_dataout", i), bus.dataout, tbl[i].exp_do);
      check32($sformatf("vec%0d_err", i), {31'b0, bus.err}, {31'b0, tbl[i].exp_err});
      check32($sformatf("vec%0d_wr_cnt", i), {16'b0, bus.wr_cnt}, {16'b0, tbl[i].exp_cnt});
    end

    // Seed the random window with known words so every later load has a defined answer.
    step(1'b1, 32'h0, 32'h0, 3'b000, 1'b0);
    err_m = 1'b0;
    cnt_m = 16'h0;
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      for (int k = 0; k < 4; k++) mem_m[w*4 + k] = 8'(d >> (8 * k));
      cnt_m = cnt_m + 16'h1;
      step(1'b0, 32'(w * 4), d, 3'b010, 1'b1);
    end
    check32("seed_wr_cnt", {16'b0, bus.wr_cnt}, {16'b0, cnt_m});

    for (int i = 0; i < 500; i++) begin
      ra = {(($urandom % 4) == 0) ? 20'($urandom) : 20'h0, 6'h0, 6'($urandom_range(0, 63))};
      rop = (($urandom % 8) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | ((($urandom % 2) == 0) ? 3'b000 : 3'b100);
      if (rop == 3'b110) rop = 3'b010;
      m_step(($urandom % 40) == 0, ra, $urandom, rop, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
